kpn_arith_node: RTL
===================

Name: kpn_arith_node

Overview:
- Parametrised successor to the two-operand adder used by the LCD datapath. Two independent input channels with valid/ready handshakes, each buffered in its own FIFO.
- The node fires when both channels hold a token: it pops one token from each, computes add or subtract, and offers the result on a valid/ready output channel with carry/borrow status and an LCD display strobe.
- Sits between the keypad/entry processes and the display process in the KPN pipeline.

Parameters:
- WIDTH, 16, operand and result width in bits.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, minimum 2.
- SATURATE, 0, 1 = clamp results (add to all-ones, sub to zero); 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in1_data  input  WIDTH  channel 1 token (first operand).
- in1_valid  input  1  channel 1 token present.
- in1_ready  output  1  channel 1 FIFO not full.
- in2_data  input  WIDTH  channel 2 token (second operand).
- in2_valid  input  1  channel 2 token present.
- in2_ready  output  1  channel 2 FIFO not full.
- mode  input  1  0 = add (op1+op2), 1 = subtract (op1-op2); sampled at pop.
- out_data  output  WIDTH  result.
- out_valid  output  1  result held, awaiting consumer.
- out_ready  input  1  consumer accepts.
- out_carry  output  1  add: carry out; sub: borrow (op1<op2); valid with out_valid.
- show_result  output  1  one-cycle pulse when a new result becomes valid (drives LCD refresh).
- result_count  output  16  number of completed output handshakes, wraps at 2^16.

Behaviour:
- Reset: all outputs 0, both FIFOs empty, FSM = WAIT, in1_ready/in2_ready = 1 on the first cycle after reset deasserts. Reset mid-operation discards all buffered tokens, held operands and the pending result.
- Input push: an edge with inN_valid=1 and inN_ready=1 writes one token. inN_ready = !full. Tokens offered while full are not accepted; the producer must hold them.
- A FIFO may push and pop on the same edge. Its count is unchanged, and a push to a FIFO at DEPTH-1 while popping is legal.
- FIFO pointers wrap modulo FIFO_DEPTH. Ordering is strictly FIFO per channel.
- FSM states:
  - WAIT: both FIFOs non-empty → pop both, latch op1/op2/mode, go COMPUTE. Otherwise stay.
  - COMPUTE: register the result into out_data/out_carry, set out_valid=1, pulse show_result for one cycle, go HOLD.
  - HOLD: out_data, out_carry and out_valid are stable until handshake. On an edge with out_ready=1:
    - clear out_valid and increment result_count;
    - if both FIFOs are non-empty on that edge, pop and go COMPUTE (back-to-back);
    - otherwise go WAIT.
- Latency: both tokens resident in their FIFOs at edge k → pop at edge k+1 → out_valid high after edge k+2. Peak throughput is one result per 2 cycles.
- Arithmetic: computed in WIDTH+1 bits.
  - add: {carry, sum} = op1 + op2.
  - sub: borrow = (op1 < op2), diff = op1 - op2 mod 2^WIDTH.
  - SATURATE=1: add with carry → out_data = all-ones; sub with borrow → out_data = 0. out_carry still reports the raw carry/borrow.
- out_ready while out_valid=0 is ignored. show_result never asserts in WAIT or HOLD.
- A single waiting operand never fires. A lone token in one FIFO waits indefinitely without blocking pushes to the other FIFO.

Test Plan:
- Basic add: WIDTH=16. Push in1=0x1234, in2=0x0101, mode=0, out_ready=1 → out_data=0x1335, out_carry=0, show_result pulses once, result_count=1.
- Wrap vs saturate:
  - SATURATE=0: push 0xFFFF and 0x0002, add → out_data=0x0001, out_carry=1.
  - SATURATE=1: same operands → out_data=0xFFFF, out_carry=1.
  - SATURATE=1: sub 0x0003-0x0005 → out_data=0x0000, out_carry=1.
- Backpressure/full: FIFO_DEPTH=4, out_ready=0.
  - Push 6 tokens on in1 and 6 on in2 → the first pair pops and is held in HOLD, 4 more pairs are stored, and in1_ready/in2_ready drop with one token pending per channel.
  - Raise out_ready → all 6 results emerge in order, result_count=6.
- Unbalanced channels: push 3 tokens on in1 only → no out_valid. Then push 1 token on in2 → exactly one result, using the first in1 token. in1 FIFO count = 2.
- Simultaneous push/pop at DEPTH-1: hold a FIFO at 3 entries while the node pops and a new token arrives on the same edge → count stays 3, no token lost or duplicated (checked by a scoreboard).
- Reset mid-operation: assert reset in HOLD with 2 tokens buffered → the next cycle shows out_valid=0, result_count=0, in1_ready=in2_ready=1, and no stale results after reset deasserts.

Source files
------------

// File: rtl/kpn_arith_node.sv
// ---------------------------------------------------------------------------
// kpn_arith_node
// Two-input arithmetic node for the KPN pipeline between the keypad/entry
// processes and the LCD display process. Each input channel has its own
// FIFO. When both FIFOs hold a token, the node pops one token from each and
// computes op1+op2 or op1-op2. It then offers the result on a valid/ready
// output channel.
//
// Parameters
//   WIDTH      operand/result width
//   FIFO_DEPTH entries per input FIFO (power of two, >= 2)
//   SATURATE   1 = clamp add overflow to all-ones and sub underflow to zero,
//              0 = wrap modulo 2^WIDTH
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   in1_data/valid/ready channel 1 (first operand) push interface
//   in2_data/valid/ready channel 2 (second operand) push interface
//   mode                 0 = add, 1 = subtract, sampled when operands pop
//   out_data/valid/ready result channel
//   out_carry            carry (add) or borrow (sub) of the held result
//   show_result          one-cycle LCD refresh strobe, high while computing
//   result_count         completed output handshakes, wraps at 2^16
// ---------------------------------------------------------------------------
module kpn_arith_node #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit SATURATE   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    input  logic             mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_carry,
    output logic             show_result,
    output logic [15:0]      result_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_COMPUTE,
        ST_HOLD
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_mem   [2][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr [2];
    logic [PTR_W-1:0] r_rdPtr [2];
    logic [CNT_W-1:0] r_count [2];

    logic [WIDTH-1:0] w_inData  [2];
    logic             w_inValid [2];
    logic             w_push    [2];
    logic             w_full    [2];
    logic             w_empty   [2];
    logic             w_pop;
    logic             w_bothReady;

    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic             r_mode;
    logic [WIDTH-1:0] r_outData;
    logic             r_outCarry;
    logic             r_outValid;
    logic [15:0]      r_resultCount;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_rawCarry;
    logic [WIDTH-1:0] w_result;

    // Channel arrays let both FIFOs share one description.
    always_comb begin
        w_inData[0]  = in1_data;
        w_inData[1]  = in2_data;
        w_inValid[0] = in1_valid;
        w_inValid[1] = in2_valid;
        for (int ch = 0; ch < 2; ch++) begin
            w_full[ch]  = (r_count[ch] == FULL_CNT);
            w_empty[ch] = (r_count[ch] == '0);
            w_push[ch]  = w_inValid[ch] && !w_full[ch];
        end
        w_bothReady = !w_empty[0] && !w_empty[1];
    end

    assign in1_ready = !w_full[0];
    assign in2_ready = !w_full[1];

    // Token storage. It has no reset because the pointers and counts
    // define which entries are live.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (!reset && w_push[ch]) begin
                r_mem[ch][r_wrPtr[ch]] <= w_inData[ch];
            end
        end
    end

    // FIFO bookkeeping. The pointers wrap naturally because the depth is a
    // power of two. A push and a pop on the same edge leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_wrPtr[ch] <= '0;
                r_rdPtr[ch] <= '0;
                r_count[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (w_push[ch]) begin
                    r_wrPtr[ch] <= r_wrPtr[ch] + 1'b1;
                end
                if (w_pop) begin
                    r_rdPtr[ch] <= r_rdPtr[ch] + 1'b1;
                end
                if (w_push[ch] && !w_pop) begin
                    r_count[ch] <= r_count[ch] + 1'b1;
                end else if (!w_push[ch] && w_pop) begin
                    r_count[ch] <= r_count[ch] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The node pops in WAIT. It can also pop in HOLD on the handshake edge,
    // so back-to-back results are produced every two cycles.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_bothReady) begin
                    w_pop       = 1'b1;
                    w_nextState = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                w_nextState = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (w_bothReady) begin
                        w_pop       = 1'b1;
                        w_nextState = ST_COMPUTE;
                    end else begin
                        w_nextState = ST_WAIT;
                    end
                end
            end
            default: begin
                w_nextState = ST_WAIT;
            end
        endcase
    end

    // The extra MSB of the WIDTH+1-bit add or subtract is the carry or the
    // borrow. The saturation clamp changes only the data; out_carry keeps the
    // raw flag.
    always_comb begin
        w_sum      = {1'b0, r_op1} + {1'b0, r_op2};
        w_diff     = {1'b0, r_op1} - {1'b0, r_op2};
        w_rawCarry = r_mode ? w_diff[WIDTH] : w_sum[WIDTH];
        w_result   = r_mode ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
        if (SATURATE && w_rawCarry) begin
            w_result = r_mode ? '0 : '1;
        end
    end

    // Operand latch, result register and handshake counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op1         <= '0;
            r_op2         <= '0;
            r_mode        <= 1'b0;
            r_outData     <= '0;
            r_outCarry    <= 1'b0;
            r_outValid    <= 1'b0;
            r_resultCount <= '0;
        end else begin
            if (w_pop) begin
                r_op1  <= r_mem[0][r_rdPtr[0]];
                r_op2  <= r_mem[1][r_rdPtr[1]];
                r_mode <= mode;
            end
            if (r_state == ST_COMPUTE) begin
                r_outData  <= w_result;
                r_outCarry <= w_rawCarry;
                r_outValid <= 1'b1;
            end else if (r_state == ST_HOLD && out_ready) begin
                r_outValid    <= 1'b0;
                r_resultCount <= r_resultCount + 16'd1;
            end
        end
    end

    assign out_data     = r_outData;
    assign out_carry    = r_outCarry;
    assign out_valid    = r_outValid;
    assign result_count = r_resultCount;
    assign show_result  = (r_state == ST_COMPUTE);

endmodule
